pll_reset_sequencer: RTL and testbench

Power-up and recovery controller for the USB PLL, which turns 16 MHz into 48 MHz. It runs on the 16 MHz reference clock, so it stays clocked while the PLL is held in reset. It drives the PLL RESETB pin and qualifies the PLL LOCK output. It releases the system reset for the 48 MHz domain only after lock has been continuously stable, and it re-sequences automatically on loss of lock, lock timeout, or a soft-reset request.

---
 rtl/pll_reset_sequencer.sv | 136 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// USB PLL power-up/recovery sequencer on the 16 MHz reference clock.
// Drives PLL RESETB, qualifies LOCK and gates the 48 MHz domain reset.
module pll_reset_sequencer #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 16384,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 7,
    parameter int RETRY_W       = 4
) (
    input  logic               clk_16mhz,
    input  logic               reset_n,
    input  logic               locked,
    input  logic               soft_reset,
    output logic               pll_resetb,
    output logic               sys_reset_n,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic [2:0]         state
);

    localparam int MAX_AB = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAXV   = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW     = $clog2(MAXV + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TO_LD    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LD   = CW'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t       st, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic         lock_m, lock_s;
    logic         fail;

    always_ff @(posedge clk_16mhz or negedge reset_n) begin
        if (!reset_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= locked;
            lock_s <= lock_m;
        end
    end

    // PLL_RST counts up from 0 so the reset value doubles as its reload;
    // WAIT_LOCK and STABLE count down to 0.
    always_comb begin
        nxt     = st;
        cnt_nxt = cnt;
        fail    = 1'b0;
        if (soft_reset && st != FAULT) begin
            nxt     = PLL_RST;
            cnt_nxt = '0;
        end else begin
            case (st)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        nxt     = WAIT_LOCK;
                        cnt_nxt = TO_LD;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        nxt     = STABLE;
                        cnt_nxt = STB_LD;
                    end else if (cnt == '0) begin
                        fail = 1'b1;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        nxt     = WAIT_LOCK;
                        cnt_nxt = TO_LD;
                    end else if (cnt == '0) begin
                        nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) fail = 1'b1;
                end
                FAULT: begin
                    nxt = FAULT;
                end
                default: begin
                    nxt     = PLL_RST;
                    cnt_nxt = '0;
                end
            endcase
            if (fail) begin
                nxt     = (retry_count >= RETRY_LIM) ? FAULT : PLL_RST;
                cnt_nxt = '0;
            end
        end
    end

    // Outputs are decoded from the next state so they toggle with st.
    always_ff @(posedge clk_16mhz or negedge reset_n) begin
        if (!reset_n) begin
            st          <= PLL_RST;
            cnt         <= '0;
            retry_count <= '0;
            pll_resetb  <= 1'b0;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            st          <= nxt;
            cnt         <= cnt_nxt;
            if (fail && retry_count != RETRY_MAX)
                retry_count <= retry_count + 1'b1;
            pll_resetb  <= (nxt == WAIT_LOCK) || (nxt == STABLE) || (nxt == RUN);
            sys_reset_n <= (nxt == RUN);
            ready       <= (nxt == RUN);
            fault       <= (nxt == FAULT);
        end
    end

    assign state = st;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with a queued expectation
// scoreboard; shortened lock timeout keeps the retry walk brief.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int RC = 16;
    localparam int LT = 200;
    localparam int SC = 1024;
    localparam int MR = 7;
    localparam int RW = 4;

    logic          clk_16mhz  = 1'b0;
    logic          reset_n    = 1'b0;
    logic          locked     = 1'b0;
    logic          soft_reset = 1'b0;
    logic          pll_resetb;
    logic          sys_reset_n;
    logic          ready;
    logic          fault;
    logic [RW-1:0] retry_count;
    logic [2:0]    state;

    pll_reset_sequencer #(
        .RESET_CYCLES (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES  (MR),
        .RETRY_W      (RW)
    ) dut (
        .clk_16mhz  (clk_16mhz),
        .reset_n    (reset_n),
        .locked     (locked),
        .soft_reset (soft_reset),
        .pll_resetb (pll_resetb),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count),
        .state      (state)
    );

    always #31.25 clk_16mhz = ~clk_16mhz;

    typedef struct {
        string   tag;
        int      st;
        int      prb;
        int      srn;
        int      rdy;
        int      flt;
        int      rc;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic cmp(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        n_chk++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_16mhz);
        #1;
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".state"},       32'(state),       32'(e.st));
        cmp({e.tag, ".pll_resetb"},  32'(pll_resetb),  32'(e.prb));
        cmp({e.tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(e.srn));
        cmp({e.tag, ".ready"},       32'(ready),       32'(e.rdy));
        cmp({e.tag, ".fault"},       32'(fault),       32'(e.flt));
        cmp({e.tag, ".retry_count"}, 32'(retry_count), 32'(e.rc));
    endtask

    task automatic step(input int n, input string tag, input int st,
                        input int prb, input int srn, input int rdy,
                        input int flt, input int rc);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        e.prb = prb;
        e.srn = srn;
        e.rdy = rdy;
        e.flt = flt;
        e.rc  = rc;
        sb.push_back(e);
        tick(n);
        pop_check();
    endtask

    initial begin
        // reset values, no clock edge needed
        #20;
        step(0, "reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk_16mhz);
        #1;
        reset_n = 1'b1;

        // clean start
        step(15, "prst_hold", 0, 0, 0, 0, 0, 0);
        step(1, "wait_entry", 1, 1, 0, 0, 0, 0);
        tick(9);
        locked = 1'b1;
        step(2, "lock_sync", 1, 1, 0, 0, 0, 0);
        step(1, "stable_entry", 2, 1, 0, 0, 0, 0);
        step(SC - 1, "stable_last", 2, 1, 0, 0, 0, 0);
        step(1, "run_entry", 3, 1, 1, 1, 0, 0);

        // loss of lock in RUN
        step(5, "run_hold", 3, 1, 1, 1, 0, 0);
        locked = 1'b0;
        step(2, "lol_sync", 3, 1, 1, 1, 0, 0);
        step(1, "lol_exit", 0, 0, 0, 0, 0, 1);
        step(RC - 1, "lol_prst", 0, 0, 0, 0, 0, 1);
        step(1, "lol_wait", 1, 1, 0, 0, 0, 1);
        locked = 1'b1;
        step(2, "relock_sync", 1, 1, 0, 0, 0, 1);
        step(1, "relock_stable", 2, 1, 0, 0, 0, 1);

        // 3-cycle glitch at STABLE cycle 500
        step(500, "glitch_pre", 2, 1, 0, 0, 0, 1);
        locked = 1'b0;
        step(2, "glitch_sync", 2, 1, 0, 0, 0, 1);
        step(1, "glitch_exit", 1, 1, 0, 0, 0, 1);
        locked = 1'b1;
        step(2, "glitch_wait", 1, 1, 0, 0, 0, 1);
        step(1, "glitch_stable", 2, 1, 0, 0, 0, 1);
        step(SC - 1, "glitch_window", 2, 1, 0, 0, 0, 1);
        step(1, "glitch_run", 3, 1, 1, 1, 0, 1);

        // soft reset in RUN, then held in WAIT_LOCK
        soft_reset = 1'b1;
        locked     = 1'b0;
        step(1, "soft_run", 0, 0, 0, 0, 0, 1);
        soft_reset = 1'b0;
        step(RC - 1, "soft_prst", 0, 0, 0, 0, 0, 1);
        step(1, "soft_wait", 1, 1, 0, 0, 0, 1);
        step(10, "wait_idle", 1, 1, 0, 0, 0, 1);
        soft_reset = 1'b1;
        step(1, "soft_wait_exit", 0, 0, 0, 0, 0, 1);
        step(49, "soft_held", 0, 0, 0, 0, 0, 1);
        soft_reset = 1'b0;
        step(RC - 1, "soft_tail", 0, 0, 0, 0, 0, 1);
        step(1, "soft_release", 1, 1, 0, 0, 0, 1);

        // lock_s rises in the final timeout cycle: lock wins
        tick(LT - 3);
        locked = 1'b1;
        step(2, "race_wait", 1, 1, 0, 0, 0, 1);
        step(1, "race_stable", 2, 1, 0, 0, 0, 1);

        // lock_s falls in the final STABLE cycle: no RUN
        tick(SC - 3);
        locked = 1'b0;
        step(2, "late_drop_hold", 2, 1, 0, 0, 0, 1);
        step(1, "late_drop_exit", 1, 1, 0, 0, 0, 1);

        // async reset mid-STABLE
        locked = 1'b1;
        step(2, "pre_async_wait", 1, 1, 0, 0, 0, 1);
        step(1, "pre_async_stable", 2, 1, 0, 0, 0, 1);
        tick(100);
        #10;
        reset_n = 1'b0;
        step(0, "async_reset", 0, 0, 0, 0, 0, 0);
        locked = 1'b0;
        #50;
        @(posedge clk_16mhz);
        #1;
        reset_n = 1'b1;
        step(RC - 1, "restart_prst", 0, 0, 0, 0, 0, 0);
        step(1, "restart_wait", 1, 1, 0, 0, 0, 0);

        // never locks: walk all retries into FAULT
        for (int k = 1; k <= MR + 1; k++) begin
            step(LT - 1, $sformatf("to%0d_wait", k), 1, 1, 0, 0, 0, k - 1);
            if (k <= MR) begin
                step(1, $sformatf("to%0d_fail", k), 0, 0, 0, 0, 0, k);
                step(RC - 1, $sformatf("to%0d_prst", k), 0, 0, 0, 0, 0, k);
                step(1, $sformatf("to%0d_rewait", k), 1, 1, 0, 0, 0, k);
            end else begin
                step(1, "to_fault", 4, 0, 0, 0, 1, MR + 1);
            end
        end
        soft_reset = 1'b1;
        step(3, "fault_soft", 4, 0, 0, 0, 1, MR + 1);
        soft_reset = 1'b0;
        #10;
        reset_n = 1'b0;
        step(0, "fault_reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk_16mhz);
        #1;
        reset_n = 1'b1;
        step(RC, "post_fault_wait", 1, 1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
